// File: rtl/mem_stage_if.sv
// Data SRAM request/response channel between the MEM stage and the data memory.
// Request fields are held stable by the master from req until addr_ok.
interface mem_stage_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE result, runs one data SRAM transaction per
// memory instruction and hands the raw read word plus byte lanes to WB.
module mem_stage #(
    parameter int EXE_TO_MEM_BUS_WD = 111,
    parameter int MEM_TO_WB_BUS_WD  = 113,
    parameter int MEM_TO_BY_BUS_WD  = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    input  logic                         EXE_to_MEM_valid,
    output logic                         MEM_allow_in,
    output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in,
    output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus,
    mem_stage_if.master                  data_sram
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                         state;
    logic                           vld_p0;
    logic [EXE_TO_MEM_BUS_WD-1:0]   bus_p0;
    logic [3:0]                     b_en_p0;
    logic [31:0]                    rdata_p0;

    logic        ready_go;
    logic        accept;
    logic        in_ram_en;
    logic [1:0]  in_wd;
    logic [1:0]  in_addr_lo;

    logic [2:0]  sel_rf_w_data_valid_stage;
    logic        sel_rf_w_en;
    logic        sel_rf_w_data;
    logic [1:0]  sel_data_ram_wd;
    logic        sel_data_ram_extend;
    logic        data_ram_en;
    logic        data_ram_we;
    logic [31:0] st_data;
    logic [4:0]  rf_w_addr;
    logic [31:0] alu_result;
    logic [31:0] inst_pc;
    logic [31:0] fwd_data;
    logic        fwd_data_valid;

    function automatic logic [3:0] lane_mask(input logic [1:0] wd, input logic [1:0] addr_lo);
        if (wd[1])
            return 4'b0001 << addr_lo;
        else if (wd[0])
            return addr_lo[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] wd, input logic [31:0] d);
        if (wd[1])
            return {4{d[7:0]}};
        else if (wd[0])
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    assign in_ram_en  = EXE_to_MEM_bus[102];
    assign in_wd      = EXE_to_MEM_bus[105:104];
    assign in_addr_lo = EXE_to_MEM_bus[33:32];

    assign {sel_rf_w_data_valid_stage, sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd,
            sel_data_ram_extend, data_ram_en, data_ram_we, st_data, rf_w_addr,
            alu_result, inst_pc} = bus_p0;

    assign ready_go        = ~data_ram_en | (state == DONE);
    assign MEM_allow_in    = ~vld_p0 | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid = vld_p0 & ready_go;
    assign accept          = EXE_to_MEM_valid & MEM_allow_in;

    // Stage register and SRAM transaction FSM; req is a registered FSM output
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0                 <= 1'b0;
            state                  <= IDLE;
            bus_p0                 <= '0;
            b_en_p0                <= '0;
            rdata_p0               <= '0;
            data_sram.data_sram_req <= 1'b0;
        end else begin
            if (MEM_allow_in)
                vld_p0 <= EXE_to_MEM_valid;
            if (accept) begin
                bus_p0   <= EXE_to_MEM_bus;
                b_en_p0  <= lane_mask(in_wd, in_addr_lo);
                rdata_p0 <= '0;
                if (in_ram_en) begin
                    state                   <= REQ;
                    data_sram.data_sram_req <= 1'b1;
                end else begin
                    state                   <= IDLE;
                    data_sram.data_sram_req <= 1'b0;
                end
            end else begin
                unique case (state)
                    REQ: begin
                        if (data_sram.data_sram_addr_ok) begin
                            state                   <= WAIT;
                            data_sram.data_sram_req <= 1'b0;
                        end
                    end
                    WAIT: begin
                        // Stores capture too; WB simply ignores the word for them
                        if (data_sram.data_sram_data_ok) begin
                            rdata_p0 <= data_sram.data_sram_rdata;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        if (WB_allow_in)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_sram.data_sram_addr  = {alu_result[31:2], 2'b00};
    assign data_sram.data_sram_wr    = data_ram_we;
    assign data_sram.data_sram_wstrb = data_ram_we ? b_en_p0 : 4'b0000;
    assign data_sram.data_sram_wdata = replicate(sel_data_ram_wd, st_data);

    assign MEM_to_WB_bus = {sel_rf_w_data_valid_stage, sel_rf_w_en, sel_rf_w_data,
                            sel_data_ram_wd, sel_data_ram_extend, b_en_p0, rdata_p0,
                            rf_w_addr, alu_result, inst_pc};

    // Loads select the memory source and therefore never forward from here
    assign fwd_data       = (rf_w_addr == 5'd0) ? 32'd0 : alu_result;
    assign fwd_data_valid = vld_p0 & ~sel_rf_w_data &
                            (sel_rf_w_data_valid_stage[0] | sel_rf_w_data_valid_stage[1]);

    assign MEM_to_BY_bus = {rf_w_addr, fwd_data, fwd_data_valid, vld_p0, sel_rf_w_en};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage with a delay-programmable data SRAM responder.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic [110:0] EXE_to_MEM_bus;
    logic         EXE_to_MEM_valid;
    logic         MEM_allow_in;
    logic [112:0] MEM_to_WB_bus;
    logic         MEM_to_WB_valid;
    logic         WB_allow_in;
    logic [39:0]  MEM_to_BY_bus;

    mem_stage_if sif();

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .EXE_to_MEM_bus   (EXE_to_MEM_bus),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .MEM_allow_in     (MEM_allow_in),
        .MEM_to_WB_bus    (MEM_to_WB_bus),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .WB_allow_in      (WB_allow_in),
        .MEM_to_BY_bus    (MEM_to_BY_bus),
        .data_sram        (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_handoff = 0;
    logic [112:0] sb[$];

    // Responder controls (written by main) and statistics (written by responder)
    int addr_delay = 1;
    int data_delay = 1;
    int stray_req  = 0;
    int stray_done = 0;
    int last_req_cycles = 0;
    int unstable = 0;
    logic [31:0] last_addr;
    logic [31:0] mem [bit [31:0]];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: sample the WB handoff just before the edge, return at negedge+1
    task automatic cyc();
        logic [112:0] exp;
        #1;
        if (MEM_to_WB_valid === 1'b1 && WB_allow_in === 1'b1) begin
            n_handoff++;
            if (sb.size() == 0)
                check("sb_underflow", sb.size(), 1);
            else begin
                exp = sb.pop_front();
                check("wb_bus", MEM_to_WB_bus, exp);
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [110:0] mk_inst(input logic [2:0] stage, input logic rf_en,
        input logic rf_sel, input logic [1:0] wd, input logic ext, input logic en,
        input logic we, input logic [31:0] st, input logic [4:0] wa,
        input logic [31:0] alu, input logic [31:0] pc);
        return {stage, rf_en, rf_sel, wd, ext, en, we, st, wa, alu, pc};
    endfunction

    function automatic logic [112:0] mk_wb(input logic [110:0] inst, input logic [3:0] ben,
        input logic [31:0] rd);
        return {inst[110:103], ben, rd, inst[68:0]};
    endfunction

    task automatic issue(input logic [110:0] inst, input logic [112:0] exp);
        int budget;
        budget = 50;
        EXE_to_MEM_bus   = inst;
        EXE_to_MEM_valid = 1'b1;
        #1;
        while (MEM_allow_in !== 1'b1 && budget > 0) begin
            cyc();
            #1;
            budget--;
        end
        if (budget == 0) check("accept_timeout", MEM_allow_in, 1);
        sb.push_back(exp);
        cyc();
        EXE_to_MEM_valid = 1'b0;
    endtask

    task automatic wait_handoff(input string tag);
        int start;
        int budget;
        start  = n_handoff;
        budget = 40;
        while (n_handoff == start && budget > 0) begin
            cyc();
            budget--;
        end
        if (n_handoff == start) check({"handoff_timeout_", tag}, n_handoff, start + 1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (MEM_to_WB_valid !== 1'b1 && cycles < 40) begin
            cyc();
            cycles++;
        end
    endtask

    // Data SRAM responder
    initial begin
        int rq_cnt;
        int dcnt;
        logic pend;
        logic p_wr;
        logic [3:0] p_strb;
        logic [31:0] p_addr, p_wdata, f_addr, f_wdata, tmp;
        logic [3:0] f_strb;
        rq_cnt = 0; dcnt = 0; pend = 1'b0;
        p_wr = 1'b0; p_strb = '0; p_addr = '0; p_wdata = '0;
        f_addr = '0; f_wdata = '0; f_strb = '0;
        mem[32'h1000] = 32'h80FF7F01;
        mem[32'h2000] = 32'h11223344;
        sif.data_sram_addr_ok = 1'b0;
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = '0;
        forever begin
            @(negedge clk);
            sif.data_sram_addr_ok = 1'b0;
            sif.data_sram_data_ok = 1'b0;
            if (reset === 1'b1) begin
                pend = 1'b0;
                rq_cnt = 0;
            end else if (stray_req != stray_done) begin
                stray_done = stray_req;
                sif.data_sram_data_ok = 1'b1;
                sif.data_sram_rdata   = 32'hBADBAD00;
            end else if (sif.data_sram_req === 1'b1) begin
                if (rq_cnt == 0) begin
                    f_addr = sif.data_sram_addr; f_wdata = sif.data_sram_wdata;
                    f_strb = sif.data_sram_wstrb;
                end else if (f_addr !== sif.data_sram_addr || f_wdata !== sif.data_sram_wdata ||
                             f_strb !== sif.data_sram_wstrb)
                    unstable++;
                rq_cnt++;
                if (rq_cnt >= addr_delay) begin
                    sif.data_sram_addr_ok = 1'b1;
                    last_req_cycles = rq_cnt;
                    last_addr = sif.data_sram_addr;
                    rq_cnt = 0;
                    pend = 1'b1;
                    dcnt = 0;
                    p_wr = sif.data_sram_wr; p_strb = sif.data_sram_wstrb;
                    p_addr = sif.data_sram_addr; p_wdata = sif.data_sram_wdata;
                end
            end else if (pend) begin
                dcnt++;
                if (dcnt >= data_delay) begin
                    pend = 1'b0;
                    sif.data_sram_data_ok = 1'b1;
                    tmp = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
                    if (p_wr) begin
                        sif.data_sram_rdata = 32'h5A5A5A5A;
                        for (int i = 0; i < 4; i++)
                            if (p_strb[i]) tmp[8*i +: 8] = p_wdata[8*i +: 8];
                        mem[p_addr] = tmp;
                    end else
                        sif.data_sram_rdata = tmp;
                end
            end
        end
    end

    // Main stimulus
    initial begin
        logic [110:0] inst;
        logic [1:0]   lane_wd   [3];
        logic [31:0]  lane_addr [3];
        logic [3:0]   lane_ben  [3];
        int n;

        reset = 1'b1;
        EXE_to_MEM_bus = '0;
        EXE_to_MEM_valid = 1'b0;
        WB_allow_in = 1'b1;
        @(negedge clk);
        #1;
        cyc();
        cyc();

        check("rst_allow_in", MEM_allow_in, 1);
        check("rst_wb_valid", MEM_to_WB_valid, 0);
        check("rst_wb_bus", MEM_to_WB_bus, 0);
        check("rst_req", sif.data_sram_req, 0);
        check("rst_mem_valid", MEM_to_BY_bus[1], 0);
        reset = 1'b0;
        cyc();

        // ALU-only op
        inst = mk_inst(3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 32'h1234, 32'h100);
        issue(inst, mk_wb(inst, 4'b1111, 32'h0));
        check("alu_wb_valid", MEM_to_WB_valid, 1);
        check("alu_no_req", sif.data_sram_req, 0);
        check("alu_fwd_data", MEM_to_BY_bus[34:3], 32'h1234);
        check("alu_fwd_valid", MEM_to_BY_bus[2], 1);
        wait_handoff("alu");

        // ld.b at 0x1002, addr_ok after 2 cycles, data_ok after a further 3
        addr_delay = 2; data_delay = 3;
        inst = mk_inst(3'b100, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0, 5'd7, 32'h1002, 32'h104);
        issue(inst, mk_wb(inst, 4'b0100, 32'h80FF7F01));
        check("ldb_req", sif.data_sram_req, 1);
        check("ldb_addr", sif.data_sram_addr, 32'h1000);
        check("ldb_wstrb", sif.data_sram_wstrb, 4'b0000);
        check("ldb_no_fwd", MEM_to_BY_bus[2], 0);
        wait_handoff("ldb");
        check("ldb_req_cycles", last_req_cycles, 2);
        check("ldb_sram_addr", last_addr, 32'h1000);

        // st.h at 0x2002, minimum-latency responses
        addr_delay = 1; data_delay = 1;
        inst = mk_inst(3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 32'hAAAABEEF, 5'd0, 32'h2002, 32'h108);
        issue(inst, mk_wb(inst, 4'b1100, 32'h5A5A5A5A));
        check("sth_wr", sif.data_sram_wr, 1);
        check("sth_wstrb", sif.data_sram_wstrb, 4'b1100);
        check("sth_wdata", sif.data_sram_wdata, 32'hBEEFBEEF);
        check("sth_addr", sif.data_sram_addr, 32'h2000);
        wait_valid(n);
        check("sth_latency", n, 2);
        wait_handoff("sth");
        check("sth_mem", mem[32'h2000], 32'hBEEF3344);

        // Lane selection table, loads from word 0x1000
        lane_wd[0] = 2'b10; lane_addr[0] = 32'h1003; lane_ben[0] = 4'b1000;
        lane_wd[1] = 2'b01; lane_addr[1] = 32'h1001; lane_ben[1] = 4'b0011;
        lane_wd[2] = 2'b00; lane_addr[2] = 32'h1000; lane_ben[2] = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            inst = mk_inst(3'b100, 1'b1, 1'b1, lane_wd[k], 1'b0, 1'b1, 1'b0, 32'h0, 5'd9,
                           lane_addr[k], 32'h200 + k);
            issue(inst, mk_wb(inst, lane_ben[k], 32'h80FF7F01));
            wait_handoff("lane");
        end
        check("req_stable", unstable, 0);

        // WB back-pressure in DONE, then handoff plus acceptance together
        WB_allow_in = 1'b0;
        inst = mk_inst(3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 5'd3, 32'h1000, 32'h300);
        issue(inst, mk_wb(inst, 4'b1111, 32'h80FF7F01));
        wait_valid(n);
        for (int k = 0; k < 4; k++) begin
            check("stall_allow_in", MEM_allow_in, 0);
            check("stall_wb_valid", MEM_to_WB_valid, 1);
            check("stall_bus", MEM_to_WB_bus, sb[0]);
            cyc();
        end
        WB_allow_in = 1'b1;
        inst = mk_inst(3'b010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 5'd4, 32'hCAFE0001, 32'h304);
        issue(inst, mk_wb(inst, 4'b1111, 32'h0));
        check("b2b_sb_left", sb.size(), 1);
        check("b2b_wb_valid", MEM_to_WB_valid, 1);
        check("b2b_fwd", MEM_to_BY_bus[34:3], 32'hCAFE0001);
        wait_handoff("b2b");

        // Reset while waiting for data_ok, then a stray data_ok
        addr_delay = 1; data_delay = 20;
        inst = mk_inst(3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 5'd6, 32'h1000, 32'h400);
        issue(inst, mk_wb(inst, 4'b1111, 32'h80FF7F01));
        cyc();
        check("wait_req_low", sif.data_sram_req, 0);
        check("wait_not_valid", MEM_to_WB_valid, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        stray_req++;
        cyc();
        cyc();
        cyc();
        check("stray_wb_valid", MEM_to_WB_valid, 0);
        check("stray_mem_valid", MEM_to_BY_bus[1], 0);
        check("stray_no_capture", MEM_to_WB_bus, 0);
        check("stray_req", sif.data_sram_req, 0);
        check("stray_allow_in", MEM_allow_in, 1);
        data_delay = 1;

        // Write to r0 never forwards a non-zero value
        inst = mk_inst(3'b010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h500);
        issue(inst, mk_wb(inst, 4'b1111, 32'h0));
        check("r0_fwd_data", MEM_to_BY_bus[34:3], 32'h0);
        check("r0_fwd_valid", MEM_to_BY_bus[2], 1);
        wait_handoff("r0");

        cyc();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
